// File: rtl/timer_snap_arb.sv
// timer_snap_arb
//
// Arbitrates 64-bit timer snapshot requests from N_REQ requesters onto a single
// timer core. The core latches its counter when it sees timer_sample and presents
// the latched value on timer_value one cycle later. Each transaction runs through
// IDLE -> SAMPLE -> CAPTURE -> ACK. The req-to-ack latency is fixed at three
// cycles, and the block accepts at most one snapshot every four cycles.
//
// Build option:
//   TIMER_SNAP_ARB_RR_EN  defined   : round-robin arbitration. The search starts
//                                     one past the last grant.
//                         undefined : fixed priority. The lowest set req index
//                                     wins, and no pointer register is built.
//
// Ports:
//   clk           in   single clock, rising edge
//   rst           in   synchronous active-high reset
//   req           in   [N_REQ]    level request, held until acked
//   ack           out  [N_REQ]    one-cycle grant pulse, snap_data valid with it
//   snap_data     out  [2*DATA_W] timer value captured for the acked requester
//   busy          out  high whenever a transaction is in flight
//   timer_sample  out  sample strobe to the timer core
//   timer_value   in   [2*DATA_W] timer core value, valid one cycle after sample

module timer_snap_arb #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    output logic [N_REQ-1:0]      ack,
    output logic [2*DATA_W-1:0]   snap_data,
    output logic                  busy,
    output logic                  timer_sample,
    input  logic [2*DATA_W-1:0]   timer_value
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] arb_idx;
    logic             req_any;
    logic             start;

    assign req_any = |req;
    // Requests are only looked at in IDLE. Anything that changes later in the
    // transaction is ignored until the FSM comes back to IDLE.
    assign start   = (state == IDLE) && req_any;

`ifdef TIMER_SNAP_ARB_RR_EN
    // last_grant is the round-robin pointer. It resets to the top index so
    // that the first search begins at requester 0.
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W:0]   cand;
    logic             found;

    // Walk every requester once, starting one past the last grant and wrapping
    // at N_REQ. cand has one extra bit so that the sum can never overflow
    // before the wrap is applied.
    always_comb begin
        arb_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, last_grant} + (IDX_W+1)'(1 + i);
            if (cand >= (IDX_W+1)'(N_REQ)) begin
                cand = cand - (IDX_W+1)'(N_REQ);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                arb_idx = cand[IDX_W-1:0];
                found   = 1'b1;
            end
        end
    end

    // The pointer advances on every entry to SAMPLE, so it always names the
    // most recent grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IDX_W'(N_REQ - 1);
        end else if (start) begin
            last_grant <= arb_idx;
        end
    end
`else
    // Fixed priority. Scanning from the top down lets the lowest set index
    // overwrite the others and win.
    always_comb begin
        arb_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                arb_idx = IDX_W'(i);
            end
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Each state after IDLE lasts exactly one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_any) state_next = SAMPLE;
            SAMPLE:  state_next = CAPTURE;
            CAPTURE: state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from state alone, so all of them return to zero as
    // soon as reset forces IDLE.
    always_comb begin
        ack          = '0;
        timer_sample = 1'b0;
        busy         = (state != IDLE);
        case (state)
            SAMPLE:  timer_sample = 1'b1;
            ACK:     ack[grant_idx] = 1'b1;
            default: ;
        endcase
    end

    // The grant index is latched at transaction start. An early drop of req
    // therefore still ends in an ack. snap_data keeps its value until the
    // next CAPTURE.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_idx <= '0;
            snap_data <= '0;
        end else begin
            if (start) begin
                grant_idx <= arb_idx;
            end
            if (state == CAPTURE) begin
                snap_data <= timer_value;
            end
        end
    end

endmodule
